// File: rtl/fpu_pkg.sv
// Shared FPU types and constants: divider state encoding, exponent bias,
// iteration count and the packed infinity magnitude.
package fpu_pkg;

    typedef enum logic [1:0] {IDLE, DIV, ROUND, DONE} fdiv_state_t;

    localparam int          FP_BIAS    = 127;
    localparam int          FDIV_ITER  = 25;
    localparam logic [30:0] FP_INF_MAG = 31'h7F800000;

endpackage

// File: rtl/fdiv_round.sv
// Combinational round-to-nearest-even and packing of a 25-bit quotient
// into an IEEE single (flush-to-zero, saturate to infinity).
module fdiv_round
    import fpu_pkg::*;
(
    input  logic [24:0]       q,
    input  logic              sticky,
    input  logic signed [9:0] ediff,
    input  logic              s,
    input  logic              z1,
    input  logic              z2,
    output logic [31:0]       y
);

    logic              round_up;
    logic [24:0]       sig_inc;
    logic [22:0]       frac;
    logic signed [9:0] exp_adj;
    logic              unused_hidden;

    // The hidden bit of the rounded significand is implicit in the packed word.
    assign unused_hidden = sig_inc[23];

    always_comb begin
        round_up = q[0] && (sticky || q[1]);
        sig_inc  = {1'b0, q[24:1]} + {24'd0, round_up};
        frac     = sig_inc[22:0];
        exp_adj  = ediff;
        // Carry out of the significand: value becomes 1.0 at the next exponent.
        if (sig_inc[24]) begin
            frac    = 23'd0;
            exp_adj = ediff + 10'sd1;
        end

        if (z1)
            y = {s, 31'd0};
        else if (z2)
            y = {s, FP_INF_MAG};
        else if (exp_adj <= 10'sd0)
            y = {s, 31'd0};
        else if (exp_adj >= 10'sd255)
            y = {s, FP_INF_MAG};
        else
            y = {s, exp_adj[7:0], frac};
    end

endmodule

// File: rtl/fdiv_seq.sv
// Iterative single-precision divider, one restoring quotient bit per clock.
// Define FDIV_EARLY_OUT_EN to finish zero-exponent operands in one cycle.
module fdiv_seq
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] x1,
    input  logic [31:0] x2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] y,
    output logic [1:0]  dbg_state
);

    // Handshake: a transfer happens on an edge where valid && ready are both
    // high; in_ready and out_valid are decoded only from the state register.

    fdiv_state_t       state, state_nx;
    logic [4:0]        cnt;
    logic [24:0]       rem;
    logic [24:0]       q;
    logic [23:0]       m2;
    logic signed [9:0] ediff;
    logic              s, z1, z2;

    logic [23:0]       m1_in, m2_in;
    logic              lt_in;
    logic [9:0]        ediff_ld;
    logic              accept;
    logic              early;
    logic              ge;
    logic [23:0]       diff;
    logic [31:0]       y_rnd;

    assign m1_in    = {1'b1, x1[22:0]};
    assign m2_in    = {1'b1, x2[22:0]};
    assign lt_in    = m1_in < m2_in;
    assign ediff_ld = {2'b00, x1[30:23]} - {2'b00, x2[30:23]} + 10'(FP_BIAS) - {9'd0, lt_in};
    assign accept   = in_valid && (state == IDLE);

    // rem < 2*m2 always, so the low 24 bits suffice for the subtraction.
    assign ge   = rem >= {1'b0, m2};
    assign diff = rem[23:0] - m2;

`ifdef FDIV_EARLY_OUT_EN
    assign early = (x1[30:23] == 8'd0) || (x2[30:23] == 8'd0);
`else
    assign early = 1'b0;
`endif

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign dbg_state = state;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = early ? DONE : DIV;
            DIV:     if (cnt == 5'd0) state_nx = ROUND;
            ROUND:   state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 5'd0;
            rem   <= 25'd0;
            q     <= 25'd0;
            m2    <= 24'd0;
            ediff <= 10'sd0;
            s     <= 1'b0;
            z1    <= 1'b0;
            z2    <= 1'b0;
            y     <= 32'd0;
        end else begin
            state <= state_nx;
            if (accept) begin
                s     <= x1[31] ^ x2[31];
                z1    <= (x1[30:23] == 8'd0);
                z2    <= (x2[30:23] == 8'd0);
                m2    <= m2_in;
                rem   <= lt_in ? {m1_in, 1'b0} : {1'b0, m1_in};
                ediff <= $signed(ediff_ld);
                cnt   <= 5'(FDIV_ITER - 1);
                q     <= 25'd0;
                if (early)
                    y <= {x1[31] ^ x2[31], (x1[30:23] == 8'd0) ? 31'd0 : FP_INF_MAG};
            end else if (state == DIV) begin
                rem <= ge ? {diff, 1'b0} : {rem[23:0], 1'b0};
                q   <= {q[23:0], ge};
                cnt <= cnt - 5'd1;
            end else if (state == ROUND) begin
                y <= y_rnd;
            end
        end
    end

    fdiv_round u_round (
        .q      (q),
        .sticky (rem != 25'd0),
        .ediff  (ediff),
        .s      (s),
        .z1     (z1),
        .z2     (z2),
        .y      (y_rnd)
    );

endmodule
